io_port_decoder: RTL and testbench
==================================

Name: io_port_decoder

Overview:
- Parametrised, registered successor to the processor I/O address decode.
- Maps a window of NUM_PORTS port addresses, starting at BASE_ADDR, onto one-hot write and read strobes, each registered with one cycle of latency.
- Also provides a registered read-data return mux for the processor in_port.
- Detects illegal accesses (out-of-window, or simultaneous read and write), sets a sticky flag and keeps a saturating error count.
- Sits between the soft processor port bus and the peripheral set (UART TX/RX, status, control registers).

Parameters:
- ADDR_W, 8: width of port_id.
- DATA_W, 8: width of the write data and of each read-data channel.
- NUM_PORTS, 16: number of decoded ports; legal range 1..2**ADDR_W.
- BASE_ADDR, 0: first decoded address; BASE_ADDR+NUM_PORTS-1 must be ≤ 2**ADDR_W-1.
- ERR_CNT_W, 8: width of the error counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- port_id  in  ADDR_W  processor port address.
- write_strobe  in  1  processor write strobe, 1-cycle pulse.
- read_strobe  in  1  processor read strobe, 1-cycle pulse.
- out_port  in  DATA_W  processor write data.
- in_data  in  NUM_PORTS*DATA_W  peripheral read data; port k occupies bits [k*DATA_W +: DATA_W].
- err_clear  in  1  clears err_flag and err_count.
- writes  out  NUM_PORTS  registered one-hot write strobes.
- reads  out  NUM_PORTS  registered one-hot read strobes.
- wr_data  out  DATA_W  out_port registered alongside writes.
- in_port  out  DATA_W  registered read data returned to the processor.
- err_flag  out  1  sticky illegal-access flag.
- err_count  out  ERR_CNT_W  saturating illegal-access count.

Behaviour:
- Reset (synchronous, active-high): writes=0, reads=0, wr_data=0, in_port=0, err_flag=0, err_count=0. Reset dominates every other input, including an access in the same cycle.
- Index and window: idx = port_id - BASE_ADDR, computed at ADDR_W+1 bits. The access is in window iff port_id ≥ BASE_ADDR and idx < NUM_PORTS.
- Legal write: write_strobe=1, read_strobe=0, in window.
  - The next cycle, writes[idx]=1 and all other bits are 0.
  - wr_data = out_port captured in the same edge.
  - writes returns to 0 the following cycle unless a new strobe arrives.
- Legal read: read_strobe=1, write_strobe=0, in window. The next cycle, reads[idx]=1 and all other bits are 0.
- in_port:
  - Updated every cycle, regardless of strobes, to in_data slice idx when in window, else 0.
  - Latency is 1 cycle from port_id, which meets the processor's 2-cycle input timing.
- wr_data holds its last value when no legal write occurs.
- Back-to-back strobes on consecutive cycles produce back-to-back output pulses. There is no throttling.
- Illegal access: either strobe with port_id out of window, or both strobes high in the same cycle.
  - No bit of writes or reads asserts for that cycle.
  - The next cycle, err_flag=1 (sticky) and err_count increments by 1.
  - err_count saturates at 2**ERR_CNT_W-1 and never wraps.
- err_clear:
  - Alone: err_flag=0 and err_count=0 the next cycle.
  - Coinciding with an illegal access: err_flag=1 and err_count=1 (the new error is kept).
- No strobes: writes=0 and reads=0. Error state is unchanged.
- There are no multi-cycle transactions, so reset in mid-stream simply drops any pending output pulse.

Decomposition:
- Shared package (io_bus_pkg):
  - ADDR_W and DATA_W defaults.
  - Standard port map constants: UART_TX_PORT, UART_RX_PORT, STATUS_PORT, CTRL_PORT.
  - Error-cause encoding constants: ERR_NONE, ERR_RANGE, ERR_RW_BOTH, for future cause capture.
- One sub-module, sat_counter (parametrised width, inc, clr, saturating), used for err_count.
- The strobe and mux logic stays inline.

Test Plan:
- Reset with reset=1 for 2 cycles while write_strobe=1, port_id=3 → all outputs 0; no writes pulse after reset is released.
- Defaults: write, port_id=5, out_port=0xA5 → the next cycle writes=0x0020 and wr_data=0xA5; the cycle after, writes=0 and wr_data stays 0xA5.
- BASE_ADDR=0x40, NUM_PORTS=4: read at port_id=0x42 with in_data[2]=0x3C → reads=0b0100 and in_port=0x3C one cycle later. Read at 0x44 → reads=0, in_port=0, err_flag=1, err_count=1.
- Both strobes high at port_id=1 → writes=0, reads=0, err_flag=1, err_count increments by 1.
- ERR_CNT_W=2: 5 consecutive illegal accesses → err_count sequence 1,2,3,3,3. Then err_clear alone → flag=0, count=0. Then err_clear with an illegal access → flag=1, count=1.
- Consecutive writes to ports 0, 15, 0 on 3 cycles → writes = 0x0001, 0x8000, 0x0001 on 3 consecutive cycles; wr_data tracks each value.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared definitions for the soft-processor port bus: default widths,
// the standard peripheral port map and the illegal-access cause codes.
package io_bus_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Standard peripheral port map (offsets within the decoded window)
    localparam int UART_TX_PORT = 0;
    localparam int UART_RX_PORT = 1;
    localparam int STATUS_PORT  = 2;
    localparam int CTRL_PORT    = 3;

    // Illegal-access cause encoding, reserved for future cause capture
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_RW_BOTH = 2'd2
    } err_cause_t;

endpackage

// File: rtl/io_port_decoder_if.sv
// Port bus between the soft processor / peripheral set and the decoder.
// master: processor and peripherals; slave: the decoder itself.
interface io_port_decoder_if #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 16,
    parameter int ERR_CNT_W = 8
);
    logic [ADDR_W-1:0]           port_id;
    logic                        write_strobe;
    logic                        read_strobe;
    logic [DATA_W-1:0]           out_port;
    logic [NUM_PORTS*DATA_W-1:0] in_data;
    logic                        err_clear;
    logic [NUM_PORTS-1:0]        writes;
    logic [NUM_PORTS-1:0]        reads;
    logic [DATA_W-1:0]           wr_data;
    logic [DATA_W-1:0]           in_port;
    logic                        err_flag;
    logic [ERR_CNT_W-1:0]        err_count;

    modport master (
        output port_id, write_strobe, read_strobe, out_port, in_data, err_clear,
        input  writes, reads, wr_data, in_port, err_flag, err_count
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port, in_data, err_clear,
        output writes, reads, wr_data, in_port, err_flag, err_count
    );
endinterface

// File: rtl/io_port_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear that coincides
// with an increment leaves the count at 1 so the new event is not lost.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);
    localparam logic [WIDTH-1:0] LP_MAX = '1;

    logic [WIDTH-1:0] r_count;

    // Count events, clear on request, stick at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= i_inc ? WIDTH'(1) : '0;
        end else if (i_inc && (r_count != LP_MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/io_port_decoder.sv
// Registered I/O port decoder: turns processor port accesses inside a
// window of NUM_PORTS addresses into one-hot write/read strobes, returns
// the addressed peripheral's read data, and records illegal accesses.
module io_port_decoder
    import io_bus_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_PORTS = 16,
    parameter int BASE_ADDR = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    io_port_decoder_if.slave  bus
);
    // One extra bit so port_id - BASE_ADDR can be compared without wrap
    localparam logic [ADDR_W:0] LP_BASE = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] LP_NUM  = (ADDR_W+1)'(NUM_PORTS);

    logic [ADDR_W:0]      w_port_ext;
    logic [ADDR_W:0]      w_idx;
    logic                 w_in_win;
    logic                 w_any_strobe;
    logic                 w_illegal;
    logic                 w_wr_legal;
    logic                 w_rd_legal;
    logic [NUM_PORTS-1:0] w_onehot;
    logic [DATA_W-1:0]    w_rd_mux;

    logic [NUM_PORTS-1:0] r_writes;
    logic [NUM_PORTS-1:0] r_reads;
    logic [DATA_W-1:0]    r_wr_data;
    logic [DATA_W-1:0]    r_in_port;
    logic                 r_err_flag;
    logic [ERR_CNT_W-1:0] w_err_count;

    assign w_port_ext   = {1'b0, bus.port_id};
    assign w_idx        = w_port_ext - LP_BASE;
    assign w_in_win     = (w_port_ext >= LP_BASE) && (w_idx < LP_NUM);
    assign w_any_strobe = bus.write_strobe | bus.read_strobe;
    assign w_illegal    = w_any_strobe &&
                          (!w_in_win || (bus.write_strobe && bus.read_strobe));
    assign w_wr_legal   = bus.write_strobe && !bus.read_strobe && w_in_win;
    assign w_rd_legal   = bus.read_strobe && !bus.write_strobe && w_in_win;
    assign w_onehot     = NUM_PORTS'(1) << w_idx;

    // Read-data return mux; out-of-window addresses return zero
    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_in_win && (w_idx == (ADDR_W+1)'(k))) begin
                w_rd_mux = bus.in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Strobe, write-data and read-data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_writes  <= '0;
            r_reads   <= '0;
            r_wr_data <= '0;
            r_in_port <= '0;
        end else begin
            r_writes  <= w_wr_legal ? w_onehot : '0;
            r_reads   <= w_rd_legal ? w_onehot : '0;
            r_in_port <= w_rd_mux;
            if (w_wr_legal) begin
                r_wr_data <= bus.out_port;
            end
        end
    end

    // Sticky error flag; a new error wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_flag <= 1'b0;
        end else if (w_illegal) begin
            r_err_flag <= 1'b1;
        end else if (bus.err_clear) begin
            r_err_flag <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_illegal),
        .i_clr   (bus.err_clear),
        .o_count (w_err_count)
    );

    assign bus.writes    = r_writes;
    assign bus.reads     = r_reads;
    assign bus.wr_data   = r_wr_data;
    assign bus.in_port   = r_in_port;
    assign bus.err_flag  = r_err_flag;
    assign bus.err_count = w_err_count;
endmodule

// File: tb/tb_io_port_decoder.sv
// Scoreboard bench for io_port_decoder: three instances cover the default
// window, an offset 4-port window and a 2-bit saturating error counter.
module tb_io_port_decoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus, steered to one instance at a time by sel
    int         sel = 0;
    logic       ws = 1'b0;
    logic       rs = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] pid = 8'hFF;
    logic [7:0] od = 8'h00;

    io_port_decoder_if #(.ADDR_W(8), .DATA_W(8), .NUM_PORTS(16), .ERR_CNT_W(8)) if0 ();
    io_port_decoder_if #(.ADDR_W(8), .DATA_W(8), .NUM_PORTS(4),  .ERR_CNT_W(8)) if1 ();
    io_port_decoder_if #(.ADDR_W(8), .DATA_W(8), .NUM_PORTS(16), .ERR_CNT_W(2)) if2 ();

    assign if0.write_strobe = (sel == 0) && ws;
    assign if0.read_strobe  = (sel == 0) && rs;
    assign if0.err_clear    = (sel == 0) && clr;
    assign if0.port_id      = (sel == 0) ? pid : 8'hFF;
    assign if0.out_port     = od;
    assign if1.write_strobe = (sel == 1) && ws;
    assign if1.read_strobe  = (sel == 1) && rs;
    assign if1.err_clear    = (sel == 1) && clr;
    assign if1.port_id      = (sel == 1) ? pid : 8'hFF;
    assign if1.out_port     = od;
    assign if2.write_strobe = (sel == 2) && ws;
    assign if2.read_strobe  = (sel == 2) && rs;
    assign if2.err_clear    = (sel == 2) && clr;
    assign if2.port_id      = (sel == 2) ? pid : 8'hFF;
    assign if2.out_port     = od;

    // Port k of the 16-port instances reads back k*0x11
    initial begin
        for (int k = 0; k < 16; k++) begin
            if0.in_data[k*8 +: 8] = 8'(k * 17);
            if2.in_data[k*8 +: 8] = 8'(k * 17);
        end
        if1.in_data = {8'h4D, 8'h3C, 8'h1B, 8'h0A};
    end

    io_port_decoder #(.ADDR_W(8), .DATA_W(8), .NUM_PORTS(16), .BASE_ADDR(0), .ERR_CNT_W(8))
        u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    io_port_decoder #(.ADDR_W(8), .DATA_W(8), .NUM_PORTS(4), .BASE_ADDR(8'h40), .ERR_CNT_W(8))
        u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    io_port_decoder #(.ADDR_W(8), .DATA_W(8), .NUM_PORTS(16), .BASE_ADDR(0), .ERR_CNT_W(2))
        u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct {
        int          cyc;
        int          dut;
        logic [15:0] wr;
        logic [15:0] rd;
        logic [7:0]  wd;
        logic [7:0]  ip;
        logic        ef;
        logic [7:0]  ec;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compare the selected instance whenever an expectation is due
    always @(negedge clk) begin
        logic [15:0] a_wr, a_rd;
        logic [7:0]  a_wd, a_ip, a_ec;
        logic        a_ef;
        exp_t        e;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
            e = exp_q.pop_front();
            case (e.dut)
                0: begin
                    a_wr = if0.writes; a_rd = if0.reads; a_wd = if0.wr_data;
                    a_ip = if0.in_port; a_ef = if0.err_flag; a_ec = if0.err_count;
                end
                1: begin
                    a_wr = 16'(if1.writes); a_rd = 16'(if1.reads); a_wd = if1.wr_data;
                    a_ip = if1.in_port; a_ef = if1.err_flag; a_ec = if1.err_count;
                end
                default: begin
                    a_wr = if2.writes; a_rd = if2.reads; a_wd = if2.wr_data;
                    a_ip = if2.in_port; a_ef = if2.err_flag; a_ec = 8'(if2.err_count);
                end
            endcase
            checks++;
            if (a_wr !== e.wr || a_rd !== e.rd || a_wd !== e.wd ||
                a_ip !== e.ip || a_ef !== e.ef || a_ec !== e.ec) begin
                failures++;
                $display("FAIL %s: got wr=%h rd=%h wd=%h ip=%h ef=%b ec=%0d want wr=%h rd=%h wd=%h ip=%h ef=%b ec=%0d",
                         e.name, a_wr, a_rd, a_wd, a_ip, a_ef, a_ec,
                         e.wr, e.rd, e.wd, e.ip, e.ef, e.ec);
            end
        end
    end

    // Drive one cycle of stimulus and queue the response expected next cycle
    task automatic step(input int d, input logic r, input logic w, input logic rd,
                        input logic [7:0] p, input logic [7:0] o, input logic c,
                        input logic [15:0] e_wr, input logic [15:0] e_rd,
                        input logic [7:0] e_wd, input logic [7:0] e_ip,
                        input logic e_ef, input logic [7:0] e_ec, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        sel = d; reset = r; ws = w; rs = rd; pid = p; od = o; clr = c;
        e.cyc = cyc_cnt + 1; e.dut = d; e.wr = e_wr; e.rd = e_rd; e.wd = e_wd;
        e.ip = e_ip; e.ef = e_ef; e.ec = e_ec; e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        int budget;
        //   dut rst ws rs pid    od    clr  writes   reads    wd     ip     ef  ec
        step(0, 1, 1, 0, 8'h03, 8'h77, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 0, 8'd0, "rst_c1");
        step(0, 1, 1, 0, 8'h03, 8'h77, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 0, 8'd0, "rst_c2");
        step(0, 0, 0, 0, 8'hFF, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 0, 8'd0, "post_rst");
        step(0, 0, 1, 0, 8'h05, 8'hA5, 0, 16'h0020, 16'h0000, 8'hA5, 8'h55, 0, 8'd0, "wr_p5");
        step(0, 0, 0, 0, 8'hFF, 8'h00, 0, 16'h0000, 16'h0000, 8'hA5, 8'h00, 0, 8'd0, "wr_hold");
        step(0, 0, 1, 0, 8'h00, 8'h11, 0, 16'h0001, 16'h0000, 8'h11, 8'h00, 0, 8'd0, "b2b_p0");
        step(0, 0, 1, 0, 8'h0F, 8'h22, 0, 16'h8000, 16'h0000, 8'h22, 8'hFF, 0, 8'd0, "b2b_p15");
        step(0, 0, 1, 0, 8'h00, 8'h33, 0, 16'h0001, 16'h0000, 8'h33, 8'h00, 0, 8'd0, "b2b_p0b");
        step(0, 0, 0, 1, 8'h07, 8'h00, 0, 16'h0000, 16'h0080, 8'h33, 8'h77, 0, 8'd0, "rd_p7");
        step(0, 0, 1, 1, 8'h01, 8'hEE, 0, 16'h0000, 16'h0000, 8'h33, 8'h11, 1, 8'd1, "both_p1");
        step(0, 0, 1, 0, 8'h20, 8'h44, 0, 16'h0000, 16'h0000, 8'h33, 8'h00, 1, 8'd2, "wr_oow");
        step(0, 0, 0, 0, 8'hFF, 8'h00, 0, 16'h0000, 16'h0000, 8'h33, 8'h00, 1, 8'd2, "err_hold");
        step(0, 0, 0, 0, 8'hFF, 8'h00, 1, 16'h0000, 16'h0000, 8'h33, 8'h00, 0, 8'd0, "clr_alone");
        step(1, 0, 0, 1, 8'h42, 8'h00, 0, 16'h0000, 16'h0004, 8'h00, 8'h3C, 0, 8'd0, "win_rd42");
        step(1, 0, 0, 1, 8'h44, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 1, 8'd1, "win_rd44");
        step(1, 0, 1, 0, 8'h3F, 8'h55, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 1, 8'd2, "win_below");
        step(1, 0, 1, 0, 8'h43, 8'h66, 0, 16'h0008, 16'h0000, 8'h66, 8'h4D, 1, 8'd2, "win_wr43");
        step(2, 0, 1, 1, 8'h02, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 8'h22, 1, 8'd1, "sat_1");
        step(2, 0, 0, 1, 8'h10, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 1, 8'd2, "sat_2");
        step(2, 0, 1, 1, 8'h02, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 8'h22, 1, 8'd3, "sat_3");
        step(2, 0, 0, 1, 8'h10, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 1, 8'd3, "sat_4");
        step(2, 0, 1, 1, 8'h02, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 8'h22, 1, 8'd3, "sat_5");
        step(2, 0, 0, 0, 8'hFF, 8'h00, 1, 16'h0000, 16'h0000, 8'h00, 8'h00, 0, 8'd0, "sat_clr");
        step(2, 0, 1, 0, 8'h80, 8'h00, 1, 16'h0000, 16'h0000, 8'h00, 8'h00, 1, 8'd1, "clr_and_err");
        step(2, 0, 1, 0, 8'h09, 8'h99, 0, 16'h0200, 16'h0000, 8'h99, 8'h99, 1, 8'd1, "wr_p9");
        step(2, 1, 1, 0, 8'h04, 8'h12, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 0, 8'd0, "mid_rst");
        step(2, 0, 0, 0, 8'hFF, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 0, 8'd0, "after_rst");

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
